histogram_frame_sequencer: RTL and testbench

- Per-frame controller for the luminance histogram pipeline.
- Sequence per frame: clears the 256-bin histogram RAM, gates pixel accumulation for exactly one frame, then runs the cumulative-histogram engine through its iStart/oDone/iRestart handshake.
- Latches the resulting 25/50/75 thresholds and max bin count into stable holding registers for the display path.
- Sits between camera frame timing and the cumulative-histogram engine.

---
 rtl/histogram_frame_sequencer_pkg.sv | 24 ++
 rtl/hist_clear_counter.sv | 43 ++++
 rtl/histogram_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_histogram_frame_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_frame_sequencer_pkg.sv
// Shared state encoding, histogram geometry and counter sizing helper
// for the per-frame histogram sequencer.
package histogram_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARM   = 3'd2,
    S_ACCUM = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_ACK   = 3'd6
  } seq_state_e;

  localparam int unsigned HIST_BINS        = 256;
  localparam int unsigned PIXELS_PER_FRAME = 800 * 480;
  localparam logic [7:0]  CLR_LAST_ADDR    = 8'(HIST_BINS - 1);

  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/hist_clear_counter.sv
// Walks the histogram RAM clear address across every bin, one write per
// cycle, after a single-cycle start request.
module hist_clear_counter
  import histogram_frame_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       we_o,
  output logic [7:0] addr_o,
  output logic       done_o
);

  logic       we_q;
  logic [7:0] addr_q;

  // Address/write-enable sequencer; parks at address 0 when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= 8'd0;
    end else if (start_i) begin
      we_q   <= 1'b1;
      addr_q <= 8'd0;
    end else if (we_q) begin
      if (addr_q == CLR_LAST_ADDR) begin
        we_q   <= 1'b0;
        addr_q <= 8'd0;
      end else begin
        we_q   <= 1'b1;
        addr_q <= addr_q + 8'd1;
      end
    end else begin
      we_q   <= we_q;
      addr_q <= addr_q;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign done_o = we_q && (addr_q == CLR_LAST_ADDR);

endmodule

// File: rtl/histogram_frame_sequencer.sv
// Per-frame controller: clears the histogram RAM, gates one frame of pixel
// accumulation, runs the cumulative engine and holds its latest results.
module histogram_frame_sequencer
  import histogram_frame_sequencer_pkg::*;
#(
  parameter int unsigned word_size    = 20,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEnable,
  input  logic                 iFrameStart,
  input  logic                 iFrameEnd,
  output logic                 oAccumEn,
  output logic                 oClrWE,
  output logic [7:0]           oClrAddr,
  output logic [word_size-1:0] oClrData,
  output logic                 oCumStart,
  output logic                 oCumRestart,
  input  logic                 iCumDone,
  input  logic [7:0]           iThresh25,
  input  logic [7:0]           iThresh50,
  input  logic [7:0]           iThresh75,
  input  logic [word_size-1:0] iMaxValue,
  output logic [7:0]           oThresh25,
  output logic [7:0]           oThresh50,
  output logic [7:0]           oThresh75,
  output logic [word_size-1:0] oMaxValue,
  output logic                 oValid,
  output logic                 oBusy,
  output logic                 oOverrun,
  output logic                 oTimeout
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned SW = cnt_width(START_CYCLES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 32'd1);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 32'd1);

  seq_state_e     state_q, state_d;
  logic [SW-1:0]  start_cnt_q, start_cnt_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           accum_en_q, cum_start_q, cum_restart_q;
  logic           valid_q, busy_q, overrun_q, timeout_q;
  logic [7:0]     thr25_q, thr50_q, thr75_q;
  logic [word_size-1:0] max_q;

  logic clr_start_s, clr_done_s;
  logic valid_s, timeout_s, overrun_s;

  hist_clear_counter u_clear (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .start_i (clr_start_s),
    .we_o    (oClrWE),
    .addr_o  (oClrAddr),
    .done_o  (clr_done_s)
  );

  // Next-state and one-cycle event decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iEnable) state_d = S_CLEAR; else state_d = S_IDLE;
      S_CLEAR: if (clr_done_s) state_d = iEnable ? S_ARM : S_IDLE;
               else state_d = S_CLEAR;
      S_ARM:   if (!iEnable) state_d = S_IDLE;
               else if (iFrameStart) state_d = S_ACCUM;
               else state_d = S_ARM;
      // Dropping enable discards the partial histogram, so it wins over frame end.
      S_ACCUM: if (!iEnable) state_d = S_CLEAR;
               else if (iFrameEnd) state_d = S_START;
               else state_d = S_ACCUM;
      S_START: if (start_cnt_q == START_LAST) state_d = S_WAIT; else state_d = S_START;
      S_WAIT:  if (iCumDone) state_d = S_ACK;
               else if (tmo_cnt_q == TMO_LAST) state_d = S_CLEAR;
               else state_d = S_WAIT;
      S_ACK:   if (!iCumDone) state_d = S_CLEAR; else state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_START) && (state_d == S_START)) start_cnt_d = start_cnt_q + SW'(1);
    else start_cnt_d = {SW{1'b0}};

    if ((state_q == S_WAIT) && (state_d == S_WAIT)) tmo_cnt_d = tmo_cnt_q + TW'(1);
    else tmo_cnt_d = {TW{1'b0}};

    valid_s     = (state_q == S_WAIT) && iCumDone;
    timeout_s   = (state_q == S_WAIT) && !iCumDone && (tmo_cnt_q == TMO_LAST);
    overrun_s   = iEnable && iFrameStart &&
                  ((state_q == S_CLEAR) || (state_q == S_START) ||
                   (state_q == S_WAIT)  || (state_q == S_ACK)   ||
                   ((state_q == S_ACCUM) && iFrameEnd));
    clr_start_s = (state_d == S_CLEAR) && (state_q != S_CLEAR);
  end

  // Sequencer state, registered controls and result holding registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= S_IDLE;
      start_cnt_q   <= {SW{1'b0}};
      tmo_cnt_q     <= {TW{1'b0}};
      accum_en_q    <= 1'b0;
      cum_start_q   <= 1'b1;
      cum_restart_q <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      thr25_q       <= 8'd0;
      thr50_q       <= 8'd0;
      thr75_q       <= 8'd0;
      max_q         <= {word_size{1'b0}};
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      accum_en_q    <= (state_d == S_ACCUM);
      // Engine is only released while it is computing or being acknowledged.
      cum_start_q   <= (state_d != S_WAIT) && (state_d != S_ACK);
      cum_restart_q <= (state_d == S_ACK);
      valid_q       <= valid_s;
      busy_q        <= (state_d != S_IDLE) && (state_d != S_ARM);
      overrun_q     <= overrun_s;
      timeout_q     <= timeout_s;
      if (valid_s) begin
        thr25_q <= iThresh25;
        thr50_q <= iThresh50;
        thr75_q <= iThresh75;
        max_q   <= iMaxValue;
      end else begin
        thr25_q <= thr25_q;
        thr50_q <= thr50_q;
        thr75_q <= thr75_q;
        max_q   <= max_q;
      end
    end
  end

  assign oAccumEn    = accum_en_q;
  assign oClrData    = {word_size{1'b0}};
  assign oCumStart   = cum_start_q;
  assign oCumRestart = cum_restart_q;
  assign oThresh25   = thr25_q;
  assign oThresh50   = thr50_q;
  assign oThresh75   = thr75_q;
  assign oMaxValue   = max_q;
  assign oValid      = valid_q;
  assign oBusy       = busy_q;
  assign oOverrun    = overrun_q;
  assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_histogram_frame_sequencer.sv
// Directed bench for the histogram frame sequencer; result pulses are checked
// by a scoreboard monitor, timing windows by the stimulus thread.
module tb_histogram_frame_sequencer;

  localparam int K_OVR = 1;
  localparam int K_VAL = 2;
  localparam int K_TMO = 3;

  typedef struct {
    int          kind;
    logic [43:0] lat;
  } exp_t;

  logic        clk;
  logic        iRst, iEnable, iFrameStart, iFrameEnd, iCumDone;
  logic [7:0]  iThresh25, iThresh50, iThresh75;
  logic [19:0] iMaxValue;
  logic        oAccumEn, oClrWE, oCumStart, oCumRestart;
  logic [7:0]  oClrAddr, oThresh25, oThresh50, oThresh75;
  logic [19:0] oClrData, oMaxValue;
  logic        oValid, oBusy, oOverrun, oTimeout;

  exp_t        sb_q[$];
  logic [43:0] lat_exp;
  int          total;
  int          bad;

  histogram_frame_sequencer #(.word_size(20), .START_CYCLES(2), .TIMEOUT(1023)) dut (
    .iClk(clk), .iRst(iRst), .iEnable(iEnable),
    .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
    .oAccumEn(oAccumEn), .oClrWE(oClrWE), .oClrAddr(oClrAddr), .oClrData(oClrData),
    .oCumStart(oCumStart), .oCumRestart(oCumRestart), .iCumDone(iCumDone),
    .iThresh25(iThresh25), .iThresh50(iThresh50), .iThresh75(iThresh75),
    .iMaxValue(iMaxValue),
    .oThresh25(oThresh25), .oThresh50(oThresh50), .oThresh75(oThresh75),
    .oMaxValue(oMaxValue), .oValid(oValid), .oBusy(oBusy),
    .oOverrun(oOverrun), .oTimeout(oTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got pulse kind %0d, required none", kind);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", 64'(kind), 64'(e.kind));
      if (kind != K_OVR)
        chk("sb_latched", 64'({oThresh25, oThresh50, oThresh75, oMaxValue}), 64'(e.lat));
    end
  endtask

  // Scoreboard monitor: every output pulse consumes one expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (oOverrun === 1'b1) pop_check(K_OVR);
      if (oValid   === 1'b1) pop_check(K_VAL);
      if (oTimeout === 1'b1) pop_check(K_TMO);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic push(input int kind);
    exp_t e;
    e.kind = kind;
    e.lat  = lat_exp;
    sb_q.push_back(e);
  endtask

  task automatic run_clear(input string nm);
    int n, err, g;
    n = 0; err = 0; g = 0;
    while (!oClrWE && g < 2000) begin @(negedge clk); g++; end
    chk({nm, "_busy"}, 64'(oBusy), 64'd1);
    chk({nm, "_cumstart"}, 64'(oCumStart), 64'd1);
    while (oClrWE && g < 2000) begin
      if (oClrAddr != n[7:0]) err++;
      n++;
      @(negedge clk);
      g++;
    end
    chk({nm, "_len"}, 64'(n), 64'd256);
    chk({nm, "_addr_order_errs"}, 64'(err), 64'd0);
  endtask

  task automatic do_frame(input int len, output int acc);
    acc = 0;
    iFrameStart = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) iFrameStart = 1'b0;
      if (oAccumEn) acc++;
      if (i == len - 1) iFrameEnd = 1'b1;
    end
    @(negedge clk);
    iFrameEnd = 1'b0;
  endtask

  task automatic wait_start_low(output int cs);
    int g;
    cs = 0; g = 0;
    while (oCumStart && g < 100) begin cs++; @(negedge clk); g++; end
  endtask

  task automatic engine_done(input int dly, input logic [43:0] vals, output int r);
    int g;
    repeat (dly) @(negedge clk);
    {iThresh25, iThresh50, iThresh75, iMaxValue} = vals;
    lat_exp = vals;
    push(K_VAL);
    iCumDone = 1'b1;
    r = 0; g = 0;
    while (!oCumRestart && g < 50) begin @(negedge clk); g++; end
    while (oCumRestart && g < 50) begin
      r++;
      if (r == 2) iCumDone = 1'b0;
      @(negedge clk);
      g++;
    end
    iCumDone = 1'b0;
  endtask

  initial begin
    int acc, cs, r, cnt;
    total = 0; bad = 0; lat_exp = 44'd0;
    iRst = 1'b1; iEnable = 1'b0; iFrameStart = 1'b0; iFrameEnd = 1'b0; iCumDone = 1'b0;
    iThresh25 = 8'd0; iThresh50 = 8'd0; iThresh75 = 8'd0; iMaxValue = 20'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({oAccumEn, oClrWE, oCumStart, oCumRestart, oValid, oBusy, oOverrun, oTimeout}),
        64'(8'b0010_0000));
    chk("reset_latched", 64'({oThresh25, oThresh50, oThresh75, oMaxValue}), 64'd0);

    // First clear after reset, then park in ARM.
    iRst = 1'b0; iEnable = 1'b1;
    run_clear("clear1");
    chk("arm_busy", 64'(oBusy), 64'd0);

    // Nominal frame of 1000 cycles with the engine finishing 258 cycles into WAIT.
    do_frame(1000, acc);
    chk("accum_len", 64'(acc), 64'd1000);
    chk("accum_off_after_end", 64'(oAccumEn), 64'd0);
    wait_start_low(cs);
    chk("cumstart_cycles", 64'(cs), 64'd2);
    engine_done(257, {8'd64, 8'd128, 8'd192, 20'd5000}, r);
    chk("restart_cycles", 64'(r), 64'd2);
    run_clear("clear2");
    chk("latched_after_valid", 64'({oThresh25, oThresh50, oThresh75, oMaxValue}),
        64'({8'd64, 8'd128, 8'd192, 20'd5000}));

    // Engine never finishes: timeout exactly 1023 cycles after WAIT entry.
    do_frame(10, acc);
    chk("accum_len_short", 64'(acc), 64'd10);
    wait_start_low(cs);
    push(K_TMO);
    cnt = 0;
    while (!oTimeout && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("timeout_delay", 64'(cnt), 64'd1023);
    run_clear("clear_after_timeout");
    chk("latched_kept", 64'({oThresh25, oThresh50, oThresh75, oMaxValue}), 64'(lat_exp));

    // Frame start during WAIT flags one overrun; the run still completes.
    do_frame(5, acc);
    wait_start_low(cs);
    iFrameStart = 1'b1;
    push(K_OVR);
    @(negedge clk);
    iFrameStart = 1'b0;
    engine_done(20, {8'd10, 8'd20, 8'd30, 20'd777}, r);
    run_clear("clear4");

    // Next frame accumulates normally; a lone start mid-frame is ignored;
    // dropping enable discards the frame.
    iFrameStart = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) iFrameStart = 1'b0;
      if (oAccumEn) acc++;
      if (i == 10) iFrameStart = 1'b1;
      if (i == 11) iFrameStart = 1'b0;
      if (i == 19) iEnable = 1'b0;
    end
    chk("accum_len_next", 64'(acc), 64'd20);
    @(negedge clk);
    chk("accum_off_on_disable", 64'(oAccumEn), 64'd0);
    run_clear("clear_on_disable");
    iFrameStart = 1'b1;
    @(negedge clk);
    iFrameStart = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_quiet", 64'({oBusy, oClrWE, oAccumEn, oCumStart}), 64'(4'b0001));

    // Start and end together in ACCUM, then reset while waiting on the engine.
    iEnable = 1'b1;
    run_clear("clear6");
    iFrameStart = 1'b1;
    @(negedge clk);
    iFrameStart = 1'b0;
    repeat (7) @(negedge clk);
    iFrameStart = 1'b1; iFrameEnd = 1'b1;
    push(K_OVR);
    @(negedge clk);
    iFrameStart = 1'b0; iFrameEnd = 1'b0;
    wait_start_low(cs);
    chk("cumstart_cycles_6", 64'(cs), 64'd2);
    repeat (5) @(negedge clk);
    iRst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ctrl", 64'({oAccumEn, oClrWE, oCumStart, oCumRestart, oValid, oBusy, oOverrun, oTimeout}),
        64'(8'b0010_0000));
    chk("rst_wait_latched", 64'({oThresh25, oThresh50, oThresh75, oMaxValue, oClrAddr}), 64'd0);
    iRst = 1'b0; iEnable = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
